// File: rtl/de_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// de_stage_reg_pkg
// Shared definitions for the Decode->Execute pipeline register:
//   - opcode encodings used by the decode/execute stages (single definition)
//   - NOP opcode driven on a pipeline bubble
//   - default stall-overrun limit
//   - pipeline-register state encoding (debug / assertion visibility)
//   - saturating 8-bit increment helper for the stall counter
// -----------------------------------------------------------------------------
package de_stage_reg_pkg;

    // Opcode encodings shared with the decoder and execute stage.
    localparam logic [4:0] OPC_NOP  = 5'b00000;
    localparam logic [4:0] OPC_ADD  = 5'b00001;
    localparam logic [4:0] OPC_LOAD = 5'b00010;
    localparam logic [4:0] OPC_LBH  = 5'b00011;
    localparam logic [4:0] OPC_LBL  = 5'b00100;
    localparam logic [4:0] OPC_SETF = 5'b00101;
    localparam logic [4:0] OPC_CPLF = 5'b00110;

    // Number of stalled cycles after which the overrun flag is raised.
    localparam int DEF_MAX_STALL = 16;

    // Register state: RUN after a load, HOLD while stalled, BUBBLE after flush.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BUBBLE = 2'd2
    } de_state_e;

    // Increment that sticks at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/de_stage_reg_fwd_hold_slot.sv
// -----------------------------------------------------------------------------
// fwd_hold_slot
// One operand's writeback-forward holding buffer. While the stage is stalled a
// forwarded writeback value is captured here so it survives until the stall
// releases; on the releasing load the operand is selected from (in priority)
// the live forward, the held value, then the register-file read data.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (discards held value)
//   capture_i  in   stalled cycle with the forward active: store fwd_data_i
//   clear_i    in   load or flush: empty the buffer
//   fwd_i      in   live forward request for this operand
//   fwd_data_i in   writeback data
//   rf_data_i  in   register-file read data
//   data_o     out  selected operand for the next Execute value
//   hold_v_o   out  buffer holds a captured value
// -----------------------------------------------------------------------------
module fwd_hold_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic              fwd_i,
    input  logic [DATA_W-1:0] fwd_data_i,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              hold_v_o
);

    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_v_q, hold_v_d;

    always_comb begin
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        if (clear_i) begin
            hold_d   = '0;
            hold_v_d = 1'b0;
        end else if (capture_i) begin
            // A later forward within the same stall overwrites an earlier one.
            hold_d   = fwd_data_i;
            hold_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
        end
    end

    // A live forward is the newest write, so it beats the held value.
    assign data_o   = fwd_i ? fwd_data_i : (hold_v_q ? hold_q : rf_data_i);
    assign hold_v_o = hold_v_q;

endmodule

// File: rtl/de_stage_reg.sv
// -----------------------------------------------------------------------------
// de_stage_reg
// Decode->Execute pipeline register. Per clock edge the priority is
// flush > stall > load:
//   load  : E outputs take the D values (one-cycle latency); operands come via
//           the forward/hold select; an invalid slot loads data but forces the
//           control outputs to a bubble.
//   stall : E outputs hold; writeback forwards are captured into hold slots;
//           the stall length is counted and a sticky overrun flag is raised on
//           the MAX_STALL-th stalled cycle.
//   flush : control outputs become a bubble; data fields hold; hold slots,
//           stall count and overrun flag clear.
//
// Ports:
//   clk, rst_n                        clock / async active-low reset
//   valid_D, opcode_D, rd_D,
//   source_reg1_D, source_reg2_D,
//   op_a_D, op_b_D, imm_D,
//   reg_write_D, mem_read_D, alu_en_D decode-stage instruction fields
//   stall_D, flush_D                  hazard-unit hold / bubble requests
//   forward_decode_A/B, wb_data_W     writeback forwarding into op_a / op_b
//   *_E                               registered instruction for Execute
//   stall_count                       cycles the current stall has lasted
//   stall_timeout                     sticky stall-overrun flag
// -----------------------------------------------------------------------------
module de_stage_reg
    import de_stage_reg_pkg::*;
#(
    parameter int         DATA_W    = 8,
    parameter int         IMM_W     = 8,
    parameter int         MAX_STALL = DEF_MAX_STALL,
    parameter logic [4:0] NOP_OPC   = OPC_NOP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_D,
    input  logic [4:0]        opcode_D,
    input  logic [2:0]        rd_D,
    input  logic [2:0]        source_reg1_D,
    input  logic [2:0]        source_reg2_D,
    input  logic [DATA_W-1:0] op_a_D,
    input  logic [DATA_W-1:0] op_b_D,
    input  logic [IMM_W-1:0]  imm_D,
    input  logic              reg_write_D,
    input  logic              mem_read_D,
    input  logic              alu_en_D,
    input  logic              stall_D,
    input  logic              flush_D,
    input  logic              forward_decode_A,
    input  logic              forward_decode_B,
    input  logic [DATA_W-1:0] wb_data_W,
    output logic              valid_E,
    output logic [4:0]        opcode_E,
    output logic [2:0]        rd_E,
    output logic [2:0]        source_reg1_E,
    output logic [2:0]        source_reg2_E,
    output logic [DATA_W-1:0] op_a_E,
    output logic [DATA_W-1:0] op_b_E,
    output logic [IMM_W-1:0]  imm_E,
    output logic              reg_write_E,
    output logic              mem_read_E,
    output logic              alu_en_E,
    output logic [7:0]        stall_count,
    output logic              stall_timeout
);

    // Count value at which a persisting stall sets the overrun flag, so the
    // flag is visible on the MAX_STALL-th stalled cycle.
    localparam logic [7:0] STALL_LIMIT_M1 = 8'(MAX_STALL - 1);

    de_state_e state_q, state_d;

    logic              do_flush, do_stall, do_load;
    logic [DATA_W-1:0] sel_a, sel_b;

    logic              valid_q,     valid_d;
    logic [4:0]        opcode_q,    opcode_d;
    logic [2:0]        rd_q,        rd_d;
    logic [2:0]        src1_q,      src1_d;
    logic [2:0]        src2_q,      src2_d;
    logic [DATA_W-1:0] op_a_q,      op_a_d;
    logic [DATA_W-1:0] op_b_q,      op_b_d;
    logic [IMM_W-1:0]  imm_q,       imm_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              alu_en_q,    alu_en_d;
    logic [7:0]        count_q,     count_d;
    logic              timeout_q,   timeout_d;

    // Flush wins over stall (branch resolved while the hazard unit stalls).
    assign do_flush = flush_D;
    assign do_stall = stall_D & ~flush_D;
    assign do_load  = ~stall_D & ~flush_D;

    fwd_hold_slot #(.DATA_W(DATA_W)) u_hold_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture_i  (do_stall & forward_decode_A),
        .clear_i    (do_load | do_flush),
        .fwd_i      (forward_decode_A),
        .fwd_data_i (wb_data_W),
        .rf_data_i  (op_a_D),
        .data_o     (sel_a),
        .hold_v_o   ()
    );

    fwd_hold_slot #(.DATA_W(DATA_W)) u_hold_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture_i  (do_stall & forward_decode_B),
        .clear_i    (do_load | do_flush),
        .fwd_i      (forward_decode_B),
        .fwd_data_i (wb_data_W),
        .rf_data_i  (op_b_D),
        .data_o     (sel_b),
        .hold_v_o   ()
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN, ST_HOLD, ST_BUBBLE: begin
                if (do_flush)      state_d = ST_BUBBLE;
                else if (do_stall) state_d = ST_HOLD;
                else               state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Execute-register next values.
    always_comb begin
        valid_d     = valid_q;
        opcode_d    = opcode_q;
        rd_d        = rd_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        imm_d       = imm_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        alu_en_d    = alu_en_q;
        count_d     = count_q;
        timeout_d   = timeout_q;

        if (do_flush) begin
            // Data fields are don't-care in a bubble and simply hold.
            valid_d     = 1'b0;
            opcode_d    = NOP_OPC;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            alu_en_d    = 1'b0;
            count_d     = 8'd0;
            timeout_d   = 1'b0;
        end else if (do_stall) begin
            count_d   = sat_inc8(count_q);
            timeout_d = timeout_q | (count_q >= STALL_LIMIT_M1);
        end else begin
            valid_d     = valid_D;
            rd_d        = rd_D;
            src1_d      = source_reg1_D;
            src2_d      = source_reg2_D;
            op_a_d      = sel_a;
            op_b_d      = sel_b;
            imm_d       = imm_D;
            count_d     = 8'd0;
            timeout_d   = 1'b0;
            // An empty decode slot still carries data but must not act.
            opcode_d    = valid_D ? opcode_D    : NOP_OPC;
            reg_write_d = valid_D ? reg_write_D : 1'b0;
            mem_read_d  = valid_D ? mem_read_D  : 1'b0;
            alu_en_d    = valid_D ? alu_en_D    : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            opcode_q    <= NOP_OPC;
            rd_q        <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            imm_q       <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            alu_en_q    <= 1'b0;
            count_q     <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            opcode_q    <= opcode_d;
            rd_q        <= rd_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            imm_q       <= imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            alu_en_q    <= alu_en_d;
            count_q     <= count_d;
            timeout_q   <= timeout_d;
        end
    end

    assign valid_E       = valid_q;
    assign opcode_E      = opcode_q;
    assign rd_E          = rd_q;
    assign source_reg1_E = src1_q;
    assign source_reg2_E = src2_q;
    assign op_a_E        = op_a_q;
    assign op_b_E        = op_b_q;
    assign imm_E         = imm_q;
    assign reg_write_E   = reg_write_q;
    assign mem_read_E    = mem_read_q;
    assign alu_en_E      = alu_en_q;
    assign stall_count   = count_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_de_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_de_stage_reg
// Directed bench for de_stage_reg, built with MAX_STALL=4. Inputs change 1ns
// after each rising edge; outputs are checked in the same quiet window.
// -----------------------------------------------------------------------------
module tb_de_stage_reg;
    import de_stage_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_D;
    logic [4:0] opcode_D;
    logic [2:0] rd_D, source_reg1_D, source_reg2_D;
    logic [7:0] op_a_D, op_b_D, imm_D;
    logic       reg_write_D, mem_read_D, alu_en_D;
    logic       stall_D, flush_D, forward_decode_A, forward_decode_B;
    logic [7:0] wb_data_W;
    logic       valid_E;
    logic [4:0] opcode_E;
    logic [2:0] rd_E, source_reg1_E, source_reg2_E;
    logic [7:0] op_a_E, op_b_E, imm_E;
    logic       reg_write_E, mem_read_E, alu_en_E;
    logic [7:0] stall_count;
    logic       stall_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    de_stage_reg #(
        .DATA_W    (8),
        .IMM_W     (8),
        .MAX_STALL (4),
        .NOP_OPC   (OPC_NOP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_D          (valid_D),
        .opcode_D         (opcode_D),
        .rd_D             (rd_D),
        .source_reg1_D    (source_reg1_D),
        .source_reg2_D    (source_reg2_D),
        .op_a_D           (op_a_D),
        .op_b_D           (op_b_D),
        .imm_D            (imm_D),
        .reg_write_D      (reg_write_D),
        .mem_read_D       (mem_read_D),
        .alu_en_D         (alu_en_D),
        .stall_D          (stall_D),
        .flush_D          (flush_D),
        .forward_decode_A (forward_decode_A),
        .forward_decode_B (forward_decode_B),
        .wb_data_W        (wb_data_W),
        .valid_E          (valid_E),
        .opcode_E         (opcode_E),
        .rd_E             (rd_E),
        .source_reg1_E    (source_reg1_E),
        .source_reg2_E    (source_reg2_E),
        .op_a_E           (op_a_E),
        .op_b_E           (op_b_E),
        .imm_E            (imm_E),
        .reg_write_E      (reg_write_E),
        .mem_read_E       (mem_read_E),
        .alu_en_E         (alu_en_E),
        .stall_count      (stall_count),
        .stall_timeout    (stall_timeout)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_D          = 1'b0;
        opcode_D         = OPC_NOP;
        rd_D             = 3'd0;
        source_reg1_D    = 3'd0;
        source_reg2_D    = 3'd0;
        op_a_D           = 8'h00;
        op_b_D           = 8'h00;
        imm_D            = 8'h00;
        reg_write_D      = 1'b0;
        mem_read_D       = 1'b0;
        alu_en_D         = 1'b0;
        stall_D          = 1'b0;
        flush_D          = 1'b0;
        forward_decode_A = 1'b0;
        forward_decode_B = 1'b0;
        wb_data_W        = 8'h00;
    endtask

    task automatic drive_instr(input logic [4:0] opc, input logic [2:0] rd,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic rw, input logic mr);
        valid_D       = 1'b1;
        opcode_D      = opc;
        rd_D          = rd;
        source_reg1_D = 3'd1;
        source_reg2_D = 3'd2;
        op_a_D        = a;
        op_b_D        = b;
        imm_D         = 8'h0F;
        reg_write_D   = rw;
        mem_read_D    = mr;
        alu_en_D      = 1'b1;
    endtask

    // Scoreboard comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_valid",   32'(valid_E),       32'h0);
        chk("rst_opcode",  32'(opcode_E),      32'(OPC_NOP));
        chk("rst_op_a",    32'(op_a_E),        32'h0);
        chk("rst_rw",      32'(reg_write_E),   32'h0);
        chk("rst_count",   32'(stall_count),   32'h0);
        chk("rst_timeout", 32'(stall_timeout), 32'h0);
        rst_n = 1'b1;

        // Plain load of a valid ADD
        drive_instr(OPC_ADD, 3'd3, 8'h12, 8'h34, 1'b1, 1'b0);
        tick();
        chk("ld_valid",  32'(valid_E),     32'h1);
        chk("ld_opcode", 32'(opcode_E),    32'(OPC_ADD));
        chk("ld_rd",     32'(rd_E),        32'h3);
        chk("ld_op_a",   32'(op_a_E),      32'h12);
        chk("ld_op_b",   32'(op_b_E),      32'h34);
        chk("ld_imm",    32'(imm_E),       32'h0F);
        chk("ld_rw",     32'(reg_write_E), 32'h1);

        // Stall holds the Execute instruction
        op_a_D = 8'h55;
        tick();
        chk("st_pre_op_a", 32'(op_a_E), 32'h55);
        stall_D = 1'b1;
        op_a_D  = 8'hAA;
        tick();
        chk("st1_op_a",  32'(op_a_E),      32'h55);
        chk("st1_count", 32'(stall_count), 32'h1);
        chk("st1_state", 32'(dut.state_q), 32'(ST_HOLD));
        tick();
        chk("st2_count", 32'(stall_count), 32'h2);
        tick();
        chk("st3_op_a",    32'(op_a_E),        32'h55);
        chk("st3_count",   32'(stall_count),   32'h3);
        chk("st3_timeout", 32'(stall_timeout), 32'h0);
        stall_D = 1'b0;
        tick();
        chk("rel_op_a",  32'(op_a_E),      32'hAA);
        chk("rel_count", 32'(stall_count), 32'h0);

        // Forward captured during a stall survives to the release
        stall_D          = 1'b1;
        forward_decode_A = 1'b1;
        forward_decode_B = 1'b1;
        wb_data_W        = 8'h77;
        tick();
        forward_decode_A = 1'b0;
        forward_decode_B = 1'b0;
        wb_data_W        = 8'h00;
        op_a_D           = 8'h00;
        tick();
        chk("fc_hold_op_a", 32'(op_a_E), 32'hAA);
        stall_D = 1'b0;
        tick();
        chk("fc_op_a", 32'(op_a_E), 32'h77);
        chk("fc_op_b", 32'(op_b_E), 32'h77);

        // Live forward on the release cycle beats the held value
        stall_D          = 1'b1;
        forward_decode_A = 1'b1;
        wb_data_W        = 8'h77;
        tick();
        forward_decode_A = 1'b0;
        tick();
        stall_D          = 1'b0;
        forward_decode_A = 1'b1;
        wb_data_W        = 8'h99;
        op_b_D           = 8'h3C;
        tick();
        forward_decode_A = 1'b0;
        chk("lf_op_a", 32'(op_a_E), 32'h99);
        chk("lf_op_b", 32'(op_b_E), 32'h3C);

        // Branch: flush and stall together, with a captured hold pending
        drive_instr(OPC_LOAD, 3'd6, 8'h40, 8'h41, 1'b1, 1'b1);
        tick();
        chk("fl_pre_valid", 32'(valid_E),    32'h1);
        chk("fl_pre_mr",    32'(mem_read_E), 32'h1);
        stall_D          = 1'b1;
        forward_decode_A = 1'b1;
        wb_data_W        = 8'h5A;
        tick();
        forward_decode_A = 1'b0;
        flush_D          = 1'b1;
        tick();
        chk("fl_valid",  32'(valid_E),                32'h0);
        chk("fl_rw",     32'(reg_write_E),            32'h0);
        chk("fl_mr",     32'(mem_read_E),             32'h0);
        chk("fl_alu",    32'(alu_en_E),               32'h0);
        chk("fl_opcode", 32'(opcode_E),               32'(OPC_NOP));
        chk("fl_count",  32'(stall_count),            32'h0);
        chk("fl_hold_a", 32'(dut.u_hold_a.hold_v_q),  32'h0);
        chk("fl_state",  32'(dut.state_q),            32'(ST_BUBBLE));
        stall_D = 1'b0;
        flush_D = 1'b0;
        drive_instr(OPC_SETF, 3'd2, 8'h21, 8'h22, 1'b1, 1'b0);
        tick();
        chk("fl_rel_valid",  32'(valid_E),     32'h1);
        chk("fl_rel_op_a",   32'(op_a_E),      32'h21);
        chk("fl_rel_opcode", 32'(opcode_E),    32'(OPC_SETF));
        chk("fl_rel_state",  32'(dut.state_q), 32'(ST_RUN));

        // Invalid decode slot: data loads, controls become a bubble
        drive_instr(OPC_ADD, 3'd5, 8'h61, 8'h62, 1'b1, 1'b1);
        valid_D = 1'b0;
        tick();
        chk("inv_valid",  32'(valid_E),     32'h0);
        chk("inv_opcode", 32'(opcode_E),    32'(OPC_NOP));
        chk("inv_rw",     32'(reg_write_E), 32'h0);
        chk("inv_mr",     32'(mem_read_E),  32'h0);
        chk("inv_alu",    32'(alu_en_E),    32'h0);
        chk("inv_rd",     32'(rd_E),        32'h5);
        chk("inv_op_a",   32'(op_a_E),      32'h61);

        // Stall overrun with MAX_STALL=4: flag from the 4th stalled cycle on
        drive_instr(OPC_LBH, 3'd4, 8'h70, 8'h71, 1'b1, 1'b0);
        tick();
        stall_D = 1'b1;
        tick();
        chk("to1_count", 32'(stall_count), 32'h1);
        chk("to1_flag",  32'(stall_timeout), 32'h0);
        tick();
        chk("to2_flag",  32'(stall_timeout), 32'h0);
        tick();
        chk("to3_flag",  32'(stall_timeout), 32'h0);
        tick();
        chk("to4_count", 32'(stall_count), 32'h4);
        chk("to4_flag",  32'(stall_timeout), 32'h1);
        tick();
        chk("to5_flag",  32'(stall_timeout), 32'h1);
        tick();
        chk("to6_count", 32'(stall_count), 32'h6);
        chk("to6_flag",  32'(stall_timeout), 32'h1);
        stall_D = 1'b0;
        tick();
        chk("to_rel_flag",  32'(stall_timeout), 32'h0);
        chk("to_rel_count", 32'(stall_count),   32'h0);

        // Reset asserted mid-stall with a capture pending
        stall_D          = 1'b1;
        forward_decode_A = 1'b1;
        wb_data_W        = 8'hE7;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid",  32'(valid_E),               32'h0);
        chk("ar_op_a",   32'(op_a_E),                32'h0);
        chk("ar_rw",     32'(reg_write_E),           32'h0);
        chk("ar_count",  32'(stall_count),           32'h0);
        chk("ar_opcode", 32'(opcode_E),              32'(OPC_NOP));
        chk("ar_hold_a", 32'(dut.u_hold_a.hold_v_q), 32'h0);
        tick();
        rst_n            = 1'b1;
        stall_D          = 1'b0;
        forward_decode_A = 1'b0;
        drive_instr(OPC_CPLF, 3'd1, 8'h31, 8'h32, 1'b0, 1'b0);
        tick();
        chk("ar_rel_op_a",  32'(op_a_E),   32'h31);
        chk("ar_rel_valid", 32'(valid_E),  32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
